// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline: load-use and
// redirect handling plus start/busy sequencing of the multi-cycle MULT/DIV unit.
module pipe_hazard_ctrl #(
    parameter int unsigned MD_LAT = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic             UsesRt_ID,
    input  logic             MemRead_EX,
    input  logic [4:0]       Rt_EX,
    input  logic             Redirect_ID,
    input  logic             MulDiv_ID,
    input  logic             HiLo_ID,
    output logic             Stall,
    output logic             Flush_IFID,
    output logic             Bubble_IDEX,
    output logic             MdStart,
    output logic             MdBusy,
    output logic [CNT_W-1:0] StallCnt
);

    localparam int unsigned DW = $clog2(MD_LAT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [DW-1:0]      dcnt_q, dcnt_d;
    logic [CNT_W-1:0]   scnt_q, scnt_d;

    logic lu;
    logic md;
    logic busy;
    logic stall_int;
    logic start_int;

    // State register, MULT/DIV down-counter and stall performance counter
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            scnt_q  <= scnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        scnt_d  = scnt_q;
        unique case (state_q)
            IDLE: begin
                if (start_int) begin
                    state_d = BUSY;
                    dcnt_d  = DW'(MD_LAT - 1);
                end
            end
            BUSY: begin
                dcnt_d = dcnt_q - DW'(1);
                if (dcnt_q == DW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Saturating count of stalled cycles
        if (stall_int && (scnt_q != {CNT_W{1'b1}})) begin
            scnt_d = scnt_q + CNT_W'(1);
        end
    end

    // Output logic; everything is forced low while reset is held
    always_comb begin
        Stall       = 1'b0;
        Flush_IFID  = 1'b0;
        Bubble_IDEX = 1'b0;
        MdStart     = 1'b0;
        MdBusy      = 1'b0;
        StallCnt    = '0;

        lu = MemRead_EX && (Rt_EX != 5'd0) &&
             ((Rt_EX == Rs_ID) || (UsesRt_ID && (Rt_EX == Rt_ID)));
        busy      = (state_q == BUSY);
        md        = busy && (MulDiv_ID || HiLo_ID);
        stall_int = lu || md;
        // md already blocks a start while busy, so only a load-use can defer it here
        start_int = !busy && MulDiv_ID && !stall_int;

        if (Rst_n) begin
            Stall       = stall_int;
            Bubble_IDEX = stall_int;
            Flush_IFID  = Redirect_ID && !stall_int;
            MdStart     = start_int;
            MdBusy      = busy;
            StallCnt    = scnt_q;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected outputs,
// a monitor pops and compares them once per cycle.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MD_LAT = 4;
    localparam int unsigned CNT_W  = 8;

    logic             Clk;
    logic             Rst_n;
    logic [4:0]       Rs_ID, Rt_ID, Rt_EX;
    logic             UsesRt_ID, MemRead_EX, Redirect_ID, MulDiv_ID, HiLo_ID;
    logic             Stall, Flush_IFID, Bubble_IDEX, MdStart, MdBusy;
    logic [CNT_W-1:0] StallCnt;

    typedef struct {
        string            name;
        logic             stall;
        logic             flush;
        logic             bubble;
        logic             start;
        logic             busy;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_cnt = 0;

    pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UsesRt_ID(UsesRt_ID),
        .MemRead_EX(MemRead_EX), .Rt_EX(Rt_EX),
        .Redirect_ID(Redirect_ID), .MulDiv_ID(MulDiv_ID), .HiLo_ID(HiLo_ID),
        .Stall(Stall), .Flush_IFID(Flush_IFID), .Bubble_IDEX(Bubble_IDEX),
        .MdStart(MdStart), .MdBusy(MdBusy), .StallCnt(StallCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input string field, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d", name, field, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the hand-computed response
    task automatic step(input string name, input logic rst,
                        input logic [4:0] rs, input logic [4:0] rt, input logic usesrt,
                        input logic memrd, input logic [4:0] rtex,
                        input logic redir, input logic muldiv, input logic hilo,
                        input logic e_stall, input logic e_flush,
                        input logic e_start, input logic e_busy);
        exp_t e;
        @(posedge Clk);
        #1;
        Rst_n = rst; Rs_ID = rs; Rt_ID = rt; UsesRt_ID = usesrt;
        MemRead_EX = memrd; Rt_EX = rtex; Redirect_ID = redir;
        MulDiv_ID = muldiv; HiLo_ID = hilo;
        e.name   = name;
        e.stall  = e_stall;
        e.flush  = e_flush;
        e.bubble = e_stall;
        e.start  = e_start;
        e.busy   = e_busy;
        e.cnt    = rst ? CNT_W'(exp_cnt) : '0;
        q.push_back(e);
        if (!rst) exp_cnt = 0;
        else if (e_stall && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
    endtask

    // Monitor: compare on the falling edge, well away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "Stall",       int'(Stall),       int'(e.stall));
                chk(e.name, "Flush_IFID",  int'(Flush_IFID),  int'(e.flush));
                chk(e.name, "Bubble_IDEX", int'(Bubble_IDEX), int'(e.bubble));
                chk(e.name, "MdStart",     int'(MdStart),     int'(e.start));
                chk(e.name, "MdBusy",      int'(MdBusy),      int'(e.busy));
                chk(e.name, "StallCnt",    int'(StallCnt),    int'(e.cnt));
            end
        end
    end

    initial begin
        int wait_cyc;
        Rst_n = 1'b0; Rs_ID = '0; Rt_ID = '0; UsesRt_ID = 1'b0; MemRead_EX = 1'b0;
        Rt_EX = '0; Redirect_ID = 1'b0; MulDiv_ID = 1'b0; HiLo_ID = 1'b0;

        //   name            rst rs  rt  ur mr rtex rd md hl | stl fl st by
        step("rst_lu",        0, 8,  0,  0, 1, 8,   1, 1, 1,   0, 0, 0, 0);
        step("rst_idle",      0, 0,  0,  0, 0, 0,   0, 0, 0,   0, 0, 0, 0);
        step("lu_rs",         1, 8,  0,  0, 1, 8,   0, 0, 0,   1, 0, 0, 0);
        step("lu_r0",         1, 0,  0,  0, 1, 0,   0, 0, 0,   0, 0, 0, 0);
        step("no_rt_use",     1, 3,  9,  0, 1, 9,   0, 0, 0,   0, 0, 0, 0);
        step("lu_rt",         1, 3,  9,  1, 1, 9,   0, 0, 0,   1, 0, 0, 0);
        step("no_load",       1, 9,  9,  1, 0, 9,   0, 0, 0,   0, 0, 0, 0);
        step("redir",         1, 1,  2,  1, 0, 5,   1, 0, 0,   0, 1, 0, 0);
        step("redir_lu",      1, 5,  2,  1, 1, 5,   1, 0, 0,   1, 0, 0, 0);
        step("md_lu_block",   1, 7,  0,  0, 1, 7,   0, 1, 0,   1, 0, 0, 0);
        step("md_start",      1, 1,  2,  1, 0, 0,   0, 1, 0,   0, 0, 1, 0);
        step("hilo_b1",       1, 0,  0,  0, 0, 0,   0, 0, 1,   1, 0, 0, 1);
        step("hilo_lu_b2",    1, 6,  0,  0, 1, 6,   1, 0, 1,   1, 0, 0, 1);
        step("hilo_b3",       1, 0,  0,  0, 0, 0,   0, 0, 1,   1, 0, 0, 1);
        step("hilo_done",     1, 0,  0,  0, 0, 0,   0, 0, 1,   0, 0, 0, 0);
        step("md1_start",     1, 0,  0,  0, 0, 0,   0, 1, 0,   0, 0, 1, 0);
        step("md2_wait1",     1, 0,  0,  0, 0, 0,   0, 1, 0,   1, 0, 0, 1);
        step("md2_wait2",     1, 0,  0,  0, 0, 0,   1, 1, 0,   1, 0, 0, 1);
        step("md2_wait3",     1, 0,  0,  0, 0, 0,   0, 1, 0,   1, 0, 0, 1);
        step("md2_start",     1, 0,  0,  0, 0, 0,   0, 1, 0,   0, 0, 1, 0);
        step("md2_busy",      1, 0,  0,  0, 0, 0,   0, 0, 0,   0, 0, 0, 1);
        step("rst_mid_busy",  0, 4,  0,  0, 1, 4,   1, 1, 1,   0, 0, 0, 0);
        step("post_rst",      1, 0,  0,  0, 0, 0,   0, 0, 0,   0, 0, 0, 0);
        step("post_rst2",     1, 0,  0,  0, 0, 0,   0, 0, 1,   0, 0, 0, 0);

        for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
            step("sat_lu",    1, 12, 0,  0, 1, 12,  0, 0, 0,   1, 0, 0, 0);
        end
        step("sat_hold",      1, 0,  0,  0, 0, 0,   0, 0, 0,   0, 0, 0, 0);
        step("sat_hold2",     1, 0,  0,  0, 0, 0,   0, 0, 0,   0, 0, 0, 0);

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge Clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        @(posedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
